// File: rtl/hp_controller.sv
// hp_controller: player HP counter with invulnerability window, heart blink
// and a damage-pulse serialiser feeding the health bar.
module hp_controller #(
    parameter int MAX_HP        = 20,
    parameter int HP_W          = 7,
    parameter int INVULN_FRAMES = 30,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     hcount_in,
    input  logic [9:0]      vcount_in,
    input  logic            hit_in,
    input  logic [3:0]      hit_amount_in,
    input  logic            heal_in,
    input  logic [3:0]      heal_amount_in,
    input  logic            round_rst_in,
    output logic [HP_W-1:0] hp_out,
    output logic            damage_out,
    output logic            invuln_out,
    output logic            blink_out,
    output logic            game_over_out
);

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    localparam logic [HP_W:0] MAX_EXT   = (HP_W+1)'(MAX_HP);
    localparam logic [7:0]    FRM_INIT  = 8'(INVULN_FRAMES);
    localparam logic [3:0]    BPH_LAST  = 4'(BLINK_FRAMES - 1);

    state_t          state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [7:0]      frm_q, frm_d;     // frames of invulnerability left
    logic [3:0]      bph_q, bph_d;     // ticks into current blink half-period
    logic            blink_q, blink_d;
    logic [4:0]      pend_q, pend_d;   // damage units not yet pulsed
    logic            dmg_q, dmg_d;

    logic            frame_tick;
    logic            hit_ok;
    logic [HP_W:0]   hit_ext;
    logic [HP_W:0]   heal_sum;
    logic [HP_W-1:0] hp_hit;
    logic [HP_W-1:0] hp_heal;
    logic [5:0]      pend_sum;
    logic [4:0]      pend_sat;

    // Shared datapath: frame tick, hit acceptance and saturating HP arithmetic
    always_comb begin
        frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        hit_ok     = hit_in && (hit_amount_in != 4'd0) && (state_q == ALIVE);
        hit_ext    = (HP_W+1)'(hit_amount_in);
        hp_hit     = ({1'b0, hp_q} <= hit_ext) ? '0 : HP_W'({1'b0, hp_q} - hit_ext);
        heal_sum   = {1'b0, hp_q} + (HP_W+1)'(heal_amount_in);
        hp_heal    = (heal_sum > MAX_EXT) ? HP_W'(MAX_EXT) : heal_sum[HP_W-1:0];
        pend_sum   = {1'b0, pend_q} + (hit_ok ? {2'b00, hit_amount_in} : 6'd0);
        pend_sat   = (pend_sum > 6'd31) ? 5'd31 : pend_sum[4:0];
    end

    // Next-state logic: hits, heals, round reset and invulnerability timing
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        frm_d   = frm_q;
        bph_d   = bph_q;
        blink_d = blink_q;
        case (state_q)
            ALIVE: begin
                if (hit_ok) begin
                    hp_d = hp_hit;
                    if (hp_hit == '0) begin
                        state_d = DEAD;
                    end else begin
                        state_d = INVULN;
                        frm_d   = FRM_INIT;
                        bph_d   = 4'd0;
                        blink_d = 1'b1;
                    end
                end else if (heal_in) begin
                    hp_d = hp_heal;
                end
            end
            INVULN: begin
                // hits are ignored here, so a concurrent heal always lands
                if (heal_in) hp_d = hp_heal;
                if (round_rst_in) begin
                    state_d = ALIVE;
                    frm_d   = 8'd0;
                    bph_d   = 4'd0;
                    blink_d = 1'b1;
                end else if (frame_tick) begin
                    if (frm_q <= 8'd1) begin
                        state_d = ALIVE;
                        frm_d   = 8'd0;
                        bph_d   = 4'd0;
                        blink_d = 1'b1;
                    end else begin
                        frm_d = frm_q - 8'd1;
                        if (bph_q >= BPH_LAST) begin
                            bph_d   = 4'd0;
                            blink_d = ~blink_q;
                        end else begin
                            bph_d = bph_q + 4'd1;
                        end
                    end
                end
            end
            DEAD: begin
                blink_d = 1'b1;
            end
            default: begin
                state_d = ALIVE;
                blink_d = 1'b1;
            end
        endcase
    end

    // Damage serialiser: one pulse per pending unit with a low cycle between,
    // newly accepted units are visible on the very next cycle
    always_comb begin
        pend_d = pend_sat;
        dmg_d  = 1'b0;
        if (!dmg_q && (pend_sat != 5'd0)) begin
            dmg_d  = 1'b1;
            pend_d = pend_sat - 5'd1;
        end
    end

    // State register with synchronous reset discarding timers and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ALIVE;
            hp_q    <= HP_W'(MAX_HP);
            frm_q   <= 8'd0;
            bph_q   <= 4'd0;
            blink_q <= 1'b1;
            pend_q  <= 5'd0;
            dmg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            frm_q   <= frm_d;
            bph_q   <= bph_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
            dmg_q   <= dmg_d;
        end
    end

    assign hp_out        = hp_q;
    assign damage_out    = dmg_q;
    assign invuln_out    = (state_q == INVULN);
    assign blink_out     = blink_q;
    assign game_over_out = (state_q == DEAD);

endmodule

// File: tb/tb_hp_controller.sv
// Self-checking bench for hp_controller: directed scenarios plus a random
// run, all checked against a rule-level model of HP, timers and pulses.
module tb_hp_controller;

    localparam int MAX_HP = 20;
    localparam int HP_W   = 7;
    localparam int IF     = 30;
    localparam int BF     = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [10:0]     hcount_in;
    logic [9:0]      vcount_in;
    logic            hit_in;
    logic [3:0]      hit_amount_in;
    logic            heal_in;
    logic [3:0]      heal_amount_in;
    logic            round_rst_in;
    logic [HP_W-1:0] hp_out;
    logic            damage_out;
    logic            invuln_out;
    logic            blink_out;
    logic            game_over_out;

    int compared = 0;
    int mismatched = 0;

    // reference model: 0 alive, 1 invulnerable, 2 dead
    int m_hp, m_mode, m_frames, m_ticks, m_pend;
    bit m_dmg;

    hp_controller #(.MAX_HP(MAX_HP), .HP_W(HP_W), .INVULN_FRAMES(IF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hit_in(hit_in), .hit_amount_in(hit_amount_in), .heal_in(heal_in),
        .heal_amount_in(heal_amount_in), .round_rst_in(round_rst_in),
        .hp_out(hp_out), .damage_out(damage_out), .invuln_out(invuln_out),
        .blink_out(blink_out), .game_over_out(game_over_out)
    );

    always #5 clk = ~clk;

    function automatic bit m_blink();
        if (m_mode != 1) return 1'b1;
        return ((m_ticks / BF) % 2) == 0;
    endfunction

    // drive one cycle of inputs, advance the model at the edge, settle #1 after
    task automatic step(input bit r, input bit h, input int ha, input bit he,
                        input int hl, input bit rr, input bit tick);
        int add, p;
        @(negedge clk);
        rst = r; hit_in = h; hit_amount_in = 4'(ha); heal_in = he;
        heal_amount_in = 4'(hl); round_rst_in = rr;
        hcount_in = tick ? 11'd0 : 11'(1 + $urandom_range(0, 600));
        vcount_in = tick ? 10'd0 : 10'($urandom_range(0, 500));
        @(posedge clk);
        if (r) begin
            m_hp = MAX_HP; m_mode = 0; m_frames = 0; m_ticks = 0; m_pend = 0; m_dmg = 0;
        end else begin
            add = 0;
            if (m_mode == 0 && h && ha > 0) begin
                add = ha;
                m_hp = (ha >= m_hp) ? 0 : m_hp - ha;
                if (m_hp == 0) m_mode = 2;
                else begin m_mode = 1; m_frames = IF; m_ticks = 0; end
            end else if (m_mode != 2) begin
                if (he) m_hp = (m_hp + hl > MAX_HP) ? MAX_HP : m_hp + hl;
                if (m_mode == 1) begin
                    if (rr) m_mode = 0;
                    else if (tick) begin
                        m_ticks++; m_frames--;
                        if (m_frames == 0) m_mode = 0;
                    end
                end
            end
            p = m_pend + add;
            if (p > 31) p = 31;
            if (!m_dmg && p > 0) begin m_dmg = 1; p--; end
            else m_dmg = 0;
            m_pend = p;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 1);
        compared++;
        if (hp_out !== 7'(MAX_HP) || damage_out !== 1'b0 || invuln_out !== 1'b0 ||
            blink_out !== 1'b1 || game_over_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: hp=%0d dmg=%b inv=%b blink=%b go=%b, want 20 0 0 1 0",
                     hp_out, damage_out, invuln_out, blink_out, game_over_out);
        end
    endtask

    task automatic test_hit_serial();
        int pulses = 0;
        int seen_at = 0;
        step(0, 1, 3, 0, 0, 0, 0);
        compared++;
        if (hp_out !== 7'd17 || invuln_out !== 1'b1) begin
            mismatched++;
            $display("FAIL hit3: hp=%0d inv=%b, want 17 1", hp_out, invuln_out);
        end
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) step(0, 0, 0, 0, 0, 0, 0);
            if (damage_out === 1'b1) begin pulses++; seen_at = seen_at | (1 << c); end
        end
        compared++;
        if (seen_at !== ((1 << 1) | (1 << 3) | (1 << 5)) || pulses != 3) begin
            mismatched++;
            $display("FAIL hit3_pulses: cycle mask=%0h count=%0d, want mask 2a count 3", seen_at, pulses);
        end
    endtask

    task automatic test_invuln_blink();
        int toggles = 0;
        bit prev;
        step(0, 1, 5, 0, 0, 0, 0);
        compared++;
        if (hp_out !== 7'd17 || invuln_out !== 1'b1 || damage_out !== 1'b0) begin
            mismatched++;
            $display("FAIL invuln_hit_ignored: hp=%0d inv=%b dmg=%b, want 17 1 0", hp_out, invuln_out, damage_out);
        end
        prev = blink_out;
        for (int t = 1; t <= IF; t++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            if (blink_out !== prev) toggles++;
            prev = blink_out;
            compared++;
            if (blink_out !== m_blink() || invuln_out !== (m_mode == 1)) begin
                mismatched++;
                $display("FAIL blink_tick%0d: blink=%b inv=%b, want %b %b", t, blink_out, invuln_out, m_blink(), m_mode == 1);
            end
            step(0, 0, 0, 0, 0, 0, 0);
        end
        compared++;
        // 7 toggles at ticks 4..28 plus the forced return to 1 at tick 30
        if (invuln_out !== 1'b0 || blink_out !== 1'b1 || toggles != 8 || hp_out !== 7'd17) begin
            mismatched++;
            $display("FAIL invuln_end: inv=%b blink=%b toggles=%0d hp=%0d, want 0 1 8 17",
                     invuln_out, blink_out, toggles, hp_out);
        end
    endtask

    task automatic test_death();
        int pulses = 0;
        step(0, 1, 15, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(34);
        compared++;
        if (hp_out !== 7'd2 || invuln_out !== 1'b0 || damage_out !== 1'b0) begin
            mismatched++;
            $display("FAIL death_setup: hp=%0d inv=%b dmg=%b, want 2 0 0", hp_out, invuln_out, damage_out);
        end
        step(0, 1, 9, 0, 0, 0, 0);
        compared++;
        if (hp_out !== 7'd0 || game_over_out !== 1'b1 || invuln_out !== 1'b0) begin
            mismatched++;
            $display("FAIL death: hp=%0d go=%b inv=%b, want 0 1 0", hp_out, game_over_out, invuln_out);
        end
        if (damage_out === 1'b1) pulses++;
        for (int c = 0; c < 24; c++) begin
            step(0, (c == 3), 4, (c == 5), 5, (c == 7), (c % 3 == 0));
            if (damage_out === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 9 || hp_out !== 7'd0 || game_over_out !== 1'b1 || blink_out !== 1'b1) begin
            mismatched++;
            $display("FAIL dead_sticky: pulses=%0d hp=%0d go=%b blink=%b, want 9 0 1 1",
                     pulses, hp_out, game_over_out, blink_out);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        compared++;
        if (game_over_out !== 1'b0 || hp_out !== 7'd20) begin
            mismatched++;
            $display("FAIL death_reset: go=%b hp=%0d, want 0 20", game_over_out, hp_out);
        end
    endtask

    task automatic test_heal();
        step(0, 1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 7, 0, 0);
        compared++;
        if (hp_out !== 7'd20) begin
            mismatched++;
            $display("FAIL heal_sat: hp=%0d, want 20", hp_out);
        end
        step(0, 1, 4, 1, 4, 0, 0);
        compared++;
        if (hp_out !== 7'd16 || invuln_out !== 1'b1) begin
            mismatched++;
            $display("FAIL hit_heal_same: hp=%0d inv=%b, want 16 1", hp_out, invuln_out);
        end
    endtask

    task automatic test_round_rst();
        int pulses = 0;
        idle(12);
        step(0, 0, 0, 0, 0, 1, 0);
        compared++;
        if (invuln_out !== 1'b0 || hp_out !== 7'd16 || blink_out !== 1'b1) begin
            mismatched++;
            $display("FAIL round_rst: inv=%b hp=%0d blink=%b, want 0 16 1", invuln_out, hp_out, blink_out);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        if (damage_out === 1'b1) pulses++;
        idle(4);
        if (damage_out === 1'b1) pulses++;
        compared++;
        if (hp_out !== 7'd16 || invuln_out !== 1'b0 || pulses != 0) begin
            mismatched++;
            $display("FAIL hit_zero: hp=%0d inv=%b pulses=%0d, want 16 0 0", hp_out, invuln_out, pulses);
        end
    endtask

    task automatic test_back_to_back_rst();
        int pulses = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 6, 0, 0, 0, 0);
        if (damage_out === 1'b1) pulses++;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        if (damage_out === 1'b1) pulses++;
        compared++;
        if (pulses != 2) begin
            mismatched++;
            $display("FAIL rst_mid_pre: pulses=%0d, want 2", pulses);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (damage_out === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 0 || hp_out !== 7'd20 || invuln_out !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid: pulses=%0d hp=%0d inv=%b, want 0 20 0", pulses, hp_out, invuln_out);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 15),
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 15),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0));
            compared++;
            if (hp_out !== 7'(m_hp) || damage_out !== m_dmg || invuln_out !== (m_mode == 1) ||
                blink_out !== m_blink() || game_over_out !== (m_mode == 2)) begin
                mismatched++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random c%0d: hp=%0d dmg=%b inv=%b blink=%b go=%b, want %0d %b %b %b %b",
                             c, hp_out, damage_out, invuln_out, blink_out, game_over_out,
                             m_hp, m_dmg, m_mode == 1, m_blink(), m_mode == 2);
            end
        end
    endtask

    initial begin
        rst = 1'b1; hit_in = 1'b0; hit_amount_in = 4'd0; heal_in = 1'b0;
        heal_amount_in = 4'd0; round_rst_in = 1'b0; hcount_in = 11'd5; vcount_in = 10'd5;
        m_hp = MAX_HP; m_mode = 0; m_frames = 0; m_ticks = 0; m_pend = 0; m_dmg = 0;
        test_reset();
        test_hit_serial();
        test_invuln_blink();
        test_death();
        test_heal();
        test_round_rst();
        test_back_to_back_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
